// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared types and constants for the SPI register bridge
// Revision: 1.0
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } spi_state_e;

    // Source selection for the next transmit byte
    typedef enum logic [1:0] {
        TX_HOLD  = 2'd0,
        TX_SIG   = 2'd1,
        TX_ZERO  = 2'd2,
        TX_FETCH = 2'd3
    } tx_sel_e;

    localparam int         CMD_READ_BIT      = 7;
    localparam logic [7:0] DEFAULT_SIGNATURE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/spi_addr_counter.sv
`default_nettype none
// ============================================================================
// spi_addr_counter : loadable wrapping address incrementer (load wins over inc)
// Revision: 1.0
// ============================================================================
module spi_addr_counter #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// spi_reg_bridge : turns SPI frames (command byte + data bytes) into register
//                  bus reads/writes with address auto-increment
// Revision: 1.0
// ============================================================================
module spi_reg_bridge #(
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] SIGNATURE = spi_pkg::DEFAULT_SIGNATURE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_spi_ss,
    input  logic              i_rx,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_wr,
    output logic              o_reg_rd,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_busy,
    output logic              o_err
);

    import spi_pkg::*;

    spi_state_e r_state;
    spi_state_e w_next;
    tx_sel_e    w_tx_sel;

    logic [7:0] r_tx_data;
    logic [7:0] r_reg_wdata;
    logic       r_reg_wr;
    logic       r_reg_rd;
    logic       r_rd_d;
    logic       r_fetch_pend;
    logic       r_err;

    logic w_load;
    logic w_inc;
    logic w_wr_set;
    logic w_rd_set;
    logic w_fetch_set;
    logic w_fetch_clr;
    logic w_err_set;
    logic w_err_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_tx_sel    = TX_HOLD;
        w_load      = 1'b0;
        w_inc       = r_reg_wr;     // write address advances the cycle after reg_wr
        w_wr_set    = 1'b0;
        w_rd_set    = 1'b0;
        w_fetch_set = 1'b0;
        w_fetch_clr = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;

        // Slave-select high wins over everything, including a coincident byte
        if (i_spi_ss) begin
            w_next      = ST_IDLE;
            w_tx_sel    = TX_SIG;
            w_fetch_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next    = ST_CMD;
                    w_err_clr = 1'b1;
                    w_tx_sel  = TX_SIG;
                end
                ST_CMD: begin
                    if (i_rx) begin
                        w_load = 1'b1;
                        if (i_rx_data[CMD_READ_BIT]) begin
                            w_next      = ST_RD;
                            w_rd_set    = 1'b1;
                            w_fetch_set = 1'b1;
                        end else begin
                            w_next   = ST_WR;
                            w_tx_sel = TX_ZERO;
                        end
                    end
                end
                ST_WR: begin
                    w_tx_sel = TX_ZERO;
                    if (i_rx) begin
                        w_wr_set  = 1'b1;
                        w_err_set = r_reg_wr;
                    end
                end
                ST_RD: begin
                    if (r_rd_d) begin
                        w_tx_sel    = TX_FETCH;
                        w_fetch_clr = 1'b1;
                    end
                    // A byte was just loaded: move on and prefetch the next one
                    if (i_tx) begin
                        w_inc       = 1'b1;
                        w_rd_set    = 1'b1;
                        w_fetch_set = 1'b1;
                        w_err_set   = r_fetch_pend;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data    <= SIGNATURE;
            r_reg_wdata  <= 8'h00;
            r_reg_wr     <= 1'b0;
            r_reg_rd     <= 1'b0;
            r_rd_d       <= 1'b0;
            r_fetch_pend <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_reg_wr <= w_wr_set;
            r_reg_rd <= w_rd_set;
            r_rd_d   <= r_reg_rd;

            if (w_wr_set) begin
                r_reg_wdata <= i_rx_data;
            end

            if (w_fetch_set) begin
                r_fetch_pend <= 1'b1;
            end else if (w_fetch_clr) begin
                r_fetch_pend <= 1'b0;
            end

            if (w_err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end

            case (w_tx_sel)
                TX_SIG:   r_tx_data <= SIGNATURE;
                TX_ZERO:  r_tx_data <= 8'h00;
                TX_FETCH: r_tx_data <= i_reg_rdata;
                default:  r_tx_data <= r_tx_data;
            endcase
        end
    end

    spi_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (i_rx_data[ADDR_W-1:0]),
        .i_inc      (w_inc),
        .o_addr     (o_reg_addr)
    );

    assign o_tx_data   = r_tx_data;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_wr    = r_reg_wr;
    assign o_reg_rd    = r_reg_rd;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_bridge : directed table, corner sequences and random frames
// Revision: 1.0
// ============================================================================
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_spi_ss;
    logic       i_rx;
    logic [7:0] i_rx_data;
    logic       i_tx;
    logic [7:0] o_tx_data;
    logic [6:0] o_reg_addr;
    logic [7:0] o_reg_wdata;
    logic       o_reg_wr;
    logic       o_reg_rd;
    logic [7:0] tb_rdata;
    logic       o_busy;
    logic       o_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem[128];
    logic [7:0]  model_mem[128];
    logic [14:0] wq[$];
    logic [6:0]  rq[$];
    logic [14:0] ewq[$];
    logic [6:0]  erq[$];
    logic [7:0]  f_mosi[8];
    logic [7:0]  f_miso[8];
    logic [7:0]  e_miso[8];

    typedef struct {
        logic [0:2][7:0] mosi;
        logic [0:2][7:0] miso;
        logic            is_wr;
        int              nacc;
        logic [0:2][6:0] aaddr;
        logic [0:2][7:0] adata;
    } vec_t;

    vec_t vt[3];

    spi_reg_bridge #(
        .ADDR_W    (7),
        .SIGNATURE (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_spi_ss    (i_spi_ss),
        .i_rx        (i_rx),
        .i_rx_data   (i_rx_data),
        .i_tx        (i_tx),
        .o_tx_data   (o_tx_data),
        .o_reg_addr  (o_reg_addr),
        .o_reg_wdata (o_reg_wdata),
        .o_reg_wr    (o_reg_wr),
        .o_reg_rd    (o_reg_rd),
        .i_reg_rdata (tb_rdata),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    // Register file seen by the bridge; read data appears the cycle after reg_rd
    always @(posedge clk) begin
        if (o_reg_wr) begin
            mem[o_reg_addr] <= o_reg_wdata;
            wq.push_back({o_reg_addr, o_reg_wdata});
        end
        if (o_reg_rd) begin
            tb_rdata <= mem[o_reg_addr];
            rq.push_back(o_reg_addr);
        end
        if (o_reg_wr && o_reg_rd) begin
            bad++;
            $display("FAIL wr_rd_overlap: reg_wr=1 reg_rd=1 required not both");
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_tx(output logic [7:0] got);
        got  = o_tx_data;
        i_tx = 1'b1;
        @(negedge clk);
        i_tx = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d);
        i_rx      = 1'b1;
        i_rx_data = d;
        @(negedge clk);
        i_rx      = 1'b0;
    endtask

    task automatic run_frame(input int len, input int gap);
        logic [7:0] got;
        i_spi_ss = 1'b0;
        cyc(2);
        for (int k = 0; k < len; k++) begin
            send_tx(got);
            f_miso[k] = got;
            cyc(gap - 1);
            send_rx(f_mosi[k]);
            cyc(gap - 1);
        end
        i_spi_ss = 1'b1;
        cyc(3);
    endtask

    task automatic clear_q();
        wq.delete();
        rq.delete();
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] got;
        logic [6:0] a;
        int         len;
        int         gap;

        rst_n     = 1'b0;
        i_spi_ss  = 1'b1;
        i_rx      = 1'b0;
        i_rx_data = 8'h00;
        i_tx      = 1'b0;
        tb_rdata  = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[7'h20] = 8'h5A;
        mem[7'h21] = 8'hC3;

        cyc(2);
        chk("reset tx_data", o_tx_data, 8'hA5);
        chk("reset reg_addr", o_reg_addr, 7'h00);
        chk("reset busy", o_busy, 1'b0);
        chk("reset err", o_err, 1'b0);
        chk("reset strobes", {o_reg_wr, o_reg_rd}, 2'b00);
        rst_n = 1'b1;
        cyc(2);

        // ---------------- directed table ----------------
        vt[0] = '{ {8'h10, 8'h11, 8'h22}, {8'hA5, 8'h00, 8'h00}, 1'b1, 2,
                   {7'h10, 7'h11, 7'h00}, {8'h11, 8'h22, 8'h00} };
        vt[1] = '{ {8'hA0, 8'hFF, 8'hFF}, {8'hA5, 8'h5A, 8'hC3}, 1'b0, 3,
                   {7'h20, 7'h21, 7'h22}, {8'h00, 8'h00, 8'h00} };
        vt[2] = '{ {8'h7F, 8'h01, 8'h02}, {8'hA5, 8'h00, 8'h00}, 1'b1, 2,
                   {7'h7F, 7'h00, 7'h00}, {8'h01, 8'h02, 8'h00} };

        for (int i = 0; i < 3; i++) begin
            clear_q();
            for (int k = 0; k < 3; k++) f_mosi[k] = vt[i].mosi[k];
            run_frame(3, 4);
            for (int k = 0; k < 3; k++)
                chk($sformatf("vec%0d miso[%0d]", i, k), f_miso[k], vt[i].miso[k]);
            if (vt[i].is_wr) begin
                chk($sformatf("vec%0d nwr", i), wq.size(), vt[i].nacc);
                chk($sformatf("vec%0d nrd", i), rq.size(), 0);
                for (int j = 0; j < vt[i].nacc && j < wq.size(); j++)
                    chk($sformatf("vec%0d wr[%0d]", i, j), wq[j], {vt[i].aaddr[j], vt[i].adata[j]});
            end else begin
                chk($sformatf("vec%0d nrd", i), rq.size(), vt[i].nacc);
                chk($sformatf("vec%0d nwr", i), wq.size(), 0);
                for (int j = 0; j < vt[i].nacc && j < rq.size(); j++)
                    chk($sformatf("vec%0d rd[%0d]", i, j), rq[j], vt[i].aaddr[j]);
            end
            chk($sformatf("vec%0d err", i), o_err, 1'b0);
            chk($sformatf("vec%0d busy", i), o_busy, 1'b0);
        end

        // ---------------- rx coincident with ss rising is dropped ----------------
        clear_q();
        i_spi_ss = 1'b0;
        cyc(2);
        send_tx(got); cyc(3); send_rx(8'h30); cyc(3);
        send_tx(got); cyc(3); send_rx(8'h99); cyc(3);
        send_tx(got); cyc(3);
        i_spi_ss  = 1'b1;
        i_rx      = 1'b1;
        i_rx_data = 8'h77;
        @(negedge clk);
        i_rx = 1'b0;
        cyc(4);
        chk("ss_rx nwr", wq.size(), 1);
        if (wq.size() > 0) chk("ss_rx wr0", wq[0], {7'h30, 8'h99});

        // ---------------- half-period of 1 clk in a read ----------------
        clear_q();
        i_spi_ss = 1'b0;
        cyc(2);
        send_rx(8'hA0);
        send_tx(got);
        cyc(2);
        chk("fast err set", o_err, 1'b1);
        i_spi_ss = 1'b1;
        cyc(3);
        chk("err sticky idle", o_err, 1'b1);

        // ---------------- abort after command + one read ----------------
        clear_q();
        i_spi_ss = 1'b0;
        cyc(1);
        chk("err cleared at frame start", o_err, 1'b0);
        chk("busy in frame", o_busy, 1'b1);
        send_rx(8'h85);
        cyc(5);
        chk("abort nrd before", rq.size(), 1);
        i_spi_ss = 1'b1;
        i_tx     = 1'b1;
        @(negedge clk);
        i_tx = 1'b0;
        chk("abort busy", o_busy, 1'b0);
        chk("abort tx_data", o_tx_data, 8'hA5);
        cyc(6);
        chk("abort nrd after", rq.size(), 1);
        if (rq.size() > 0) chk("abort rd0", rq[0], 7'h05);

        // ---------------- async reset in the middle of RD ----------------
        clear_q();
        i_spi_ss = 1'b0;
        cyc(2);
        send_rx(8'hA0);
        cyc(5);
        send_tx(got);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst mid tx_data", o_tx_data, 8'hA5);
        chk("rst mid addr", o_reg_addr, 7'h00);
        chk("rst mid wdata", o_reg_wdata, 8'h00);
        chk("rst mid strobes", {o_reg_wr, o_reg_rd}, 2'b00);
        chk("rst mid busy/err", {o_busy, o_err}, 2'b00);
        i_spi_ss = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);

        // ---------------- random frames vs reference model ----------------
        for (int i = 0; i < 128; i++) model_mem[i] = mem[i];
        for (int f = 0; f < 30; f++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cmd[6:0] = 7'($urandom_range(124, 127));
            len = $urandom_range(1, 5);
            gap = $urandom_range(4, 6);
            f_mosi[0] = cmd;
            for (int k = 1; k < len; k++) f_mosi[k] = 8'($urandom);

            ewq.delete();
            erq.delete();
            a = cmd[6:0];
            e_miso[0] = 8'hA5;
            if (cmd[7]) begin
                for (int k = 0; k < len; k++) erq.push_back(a + 7'(k));
                for (int k = 1; k < len; k++) e_miso[k] = model_mem[a + 7'(k - 1)];
            end else begin
                for (int k = 1; k < len; k++) begin
                    e_miso[k] = 8'h00;
                    ewq.push_back({a + 7'(k - 1), f_mosi[k]});
                    model_mem[a + 7'(k - 1)] = f_mosi[k];
                end
            end

            clear_q();
            run_frame(len, gap);
            for (int k = 0; k < len; k++)
                chk($sformatf("rnd%0d miso[%0d]", f, k), f_miso[k], e_miso[k]);
            chk($sformatf("rnd%0d nwr", f), wq.size(), ewq.size());
            chk($sformatf("rnd%0d nrd", f), rq.size(), erq.size());
            for (int j = 0; j < ewq.size() && j < wq.size(); j++)
                chk($sformatf("rnd%0d wr[%0d]", f, j), wq[j], ewq[j]);
            for (int j = 0; j < erq.size() && j < rq.size(); j++)
                chk($sformatf("rnd%0d rd[%0d]", f, j), rq[j], erq[j]);
            chk($sformatf("rnd%0d err", f), o_err, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
